// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and redirect controller for the 5-stage pipeline: per-stage stall/flush/bubble
// controls, a held fetch redirect, and wrapping redirect / load-use event counters.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | normal flow; jumps are accepted, load-use hazards detected
// S_REDIRECT | redirect held to fetch until if_redirect_ack; jumps ignored
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_jump_signal,
  input  logic [ADDR_WIDTH-1:0] ex_jump_pc,
  input  logic                  ex_ready,
  input  logic                  ex_is_mem_load,
  input  logic [4:0]            ex_dst_reg,
  input  logic [4:0]            id_src1,
  input  logic [4:0]            id_src2,
  input  logic                  id_uses_src2,
  input  logic                  if_redirect_ack,
  output logic                  if_redirect_valid,
  output logic [ADDR_WIDTH-1:0] if_redirect_pc,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  bubble_ex,
  output logic [CNT_WIDTH-1:0]  redirect_count,
  output logic [CNT_WIDTH-1:0]  loaduse_count
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  redirect_cnt_q, redirect_cnt_d;
  logic [CNT_WIDTH-1:0]  loaduse_cnt_q, loaduse_cnt_d;

  logic in_idle;
  logic jump_accept;
  logic src_match;
  logic load_use_hit;
  logic load_use_stall;

  assign in_idle     = (state_q == S_IDLE);
  assign jump_accept = in_idle && ex_jump_signal && ex_ready;

  assign src_match    = (ex_dst_reg == id_src1) ||
                        (id_uses_src2 && (ex_dst_reg == id_src2));
  assign load_use_hit = in_idle && ex_is_mem_load && (ex_dst_reg != 5'd0) && src_match;

  // Only a load-use stall that actually inserts a bubble is counted.
  assign load_use_stall = load_use_hit && ex_ready && !jump_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (jump_accept)     state_d = S_REDIRECT;
      S_REDIRECT: if (if_redirect_ack) state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d           = pc_q;
    redirect_cnt_d = redirect_cnt_q;
    loaduse_cnt_d  = loaduse_cnt_q;
    if (jump_accept) begin
      pc_d           = ex_jump_pc;
      redirect_cnt_d = redirect_cnt_q + 1'b1;
    end
    if (load_use_stall) begin
      loaduse_cnt_d = loaduse_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q           <= '0;
      redirect_cnt_q <= '0;
      loaduse_cnt_q  <= '0;
    end else begin
      pc_q           <= pc_d;
      redirect_cnt_q <= redirect_cnt_d;
      loaduse_cnt_q  <= loaduse_cnt_d;
    end
  end

  // Reset gates the combinational controls too, so nothing leaks out while held.
  always_comb begin
    if_redirect_valid = 1'b0;
    stall_if          = 1'b0;
    stall_id          = 1'b0;
    flush_if_id       = 1'b0;
    flush_id_ex       = 1'b0;
    bubble_ex         = 1'b0;
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          if (jump_accept) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (!ex_ready) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
          end else if (load_use_hit) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        S_REDIRECT: begin
          if_redirect_valid = 1'b1;
          flush_if_id       = 1'b1;
          stall_id          = !ex_ready;
        end
        default: ;
      endcase
    end
  end

  assign if_redirect_pc = pc_q;
  assign redirect_count = redirect_cnt_q;
  assign loaduse_count  = loaduse_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; counters narrowed to 8 bits so wrap is reachable quickly.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_jump_signal, ex_ready, ex_is_mem_load, id_uses_src2, if_redirect_ack;
  logic [AW-1:0] ex_jump_pc;
  logic [4:0]    ex_dst_reg, id_src1, id_src2;
  logic          if_redirect_valid, stall_if, stall_id, flush_if_id, flush_id_ex, bubble_ex;
  logic [AW-1:0] if_redirect_pc;
  logic [CW-1:0] redirect_count, loaduse_count;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .ex_jump_signal(ex_jump_signal), .ex_jump_pc(ex_jump_pc), .ex_ready(ex_ready),
    .ex_is_mem_load(ex_is_mem_load), .ex_dst_reg(ex_dst_reg),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .if_redirect_ack(if_redirect_ack),
    .if_redirect_valid(if_redirect_valid), .if_redirect_pc(if_redirect_pc),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .bubble_ex(bubble_ex),
    .redirect_count(redirect_count), .loaduse_count(loaduse_count)
  );

  always #5 clk = ~clk;

  // ctrl = {valid, stall_if, stall_id, flush_if_id, flush_id_ex, bubble_ex}
  wire [5:0] ctrl = {if_redirect_valid, stall_if, stall_id, flush_if_id, flush_id_ex, bubble_ex};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_jump_signal = 0; ex_ready = 1; ex_is_mem_load = 0; id_uses_src2 = 0;
    if_redirect_ack = 0; ex_jump_pc = '0; ex_dst_reg = 0; id_src1 = 0; id_src2 = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0; ex_jump_signal = 1; ex_jump_pc = 64'h64;
    #3;
    chk("rst_ctrl", 64'(ctrl), 64'b000000);
    chk("rst_rcnt", 64'(redirect_count), 0);
    tick(); tick();
    chk("rst_hold_ctrl", 64'(ctrl), 64'b000000);
    chk("rst_hold_pc", if_redirect_pc, 0);
    #2;
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk("post_rst_ctrl", 64'(ctrl), 64'b000000);
    chk("post_rst_rcnt", 64'(redirect_count), 0);
    chk("post_rst_lcnt", 64'(loaduse_count), 0);

    // basic jump with ack delayed
    ex_jump_signal = 1; ex_jump_pc = 64'h64; #1;
    chk("jump_accept_ctrl", 64'(ctrl), 64'b000110);
    tick(); ex_jump_signal = 0; ex_jump_pc = '0; #1;
    chk("redir1_ctrl", 64'(ctrl), 64'b100100);
    chk("redir1_pc", if_redirect_pc, 64'h64);
    chk("redir1_rcnt", 64'(redirect_count), 1);
    tick();
    chk("redir2_ctrl", 64'(ctrl), 64'b100100);
    tick();
    chk("redir3_pc", if_redirect_pc, 64'h64);
    tick(); if_redirect_ack = 1; #1;
    chk("redir4_ack_ctrl", 64'(ctrl), 64'b100100);
    tick(); if_redirect_ack = 0; #1;
    chk("after_ack_ctrl", 64'(ctrl), 64'b000000);
    chk("after_ack_rcnt", 64'(redirect_count), 1);

    // load-use via src2
    ex_is_mem_load = 1; ex_dst_reg = 5; id_src2 = 5; id_uses_src2 = 1; #1;
    chk("lu_src2_ctrl", 64'(ctrl), 64'b011001);
    tick(); ex_is_mem_load = 0; #1;
    chk("lu_src2_cleared", 64'(ctrl), 64'b000000);
    chk("lu_src2_lcnt", 64'(loaduse_count), 1);
    ex_is_mem_load = 1; id_uses_src2 = 0; #1;
    chk("lu_imm_ctrl", 64'(ctrl), 64'b000000);
    tick();
    chk("lu_imm_lcnt", 64'(loaduse_count), 1);
    ex_dst_reg = 0; id_src1 = 0; id_src2 = 0; id_uses_src2 = 1; #1;
    chk("lu_r0_ctrl", 64'(ctrl), 64'b000000);
    tick();
    chk("lu_r0_lcnt", 64'(loaduse_count), 1);
    ex_dst_reg = 7; id_src1 = 7; id_src2 = 3; #1;
    chk("lu_src1_ctrl", 64'(ctrl), 64'b011001);
    tick(); ex_is_mem_load = 0; #1;
    chk("lu_src1_lcnt", 64'(loaduse_count), 2);

    // jump beats load-use
    ex_is_mem_load = 1; ex_dst_reg = 5; id_src1 = 5; ex_jump_signal = 1; ex_jump_pc = 64'h64; #1;
    chk("prio_jump_lu_ctrl", 64'(ctrl), 64'b000110);
    tick(); ex_jump_signal = 0; #1;
    chk("prio_lcnt", 64'(loaduse_count), 2);
    chk("prio_rcnt", 64'(redirect_count), 2);
    chk("prio_redir_ctrl", 64'(ctrl), 64'b100100);

    // jump in REDIRECT is ignored
    ex_jump_signal = 1; ex_jump_pc = 64'h200; #1;
    chk("ign_ctrl", 64'(ctrl), 64'b100100);
    tick(); ex_jump_signal = 0; #1;
    chk("ign_pc", if_redirect_pc, 64'h64);
    chk("ign_rcnt", 64'(redirect_count), 2);
    if_redirect_ack = 1;
    tick(); if_redirect_ack = 0; ex_is_mem_load = 0; #1;
    chk("ign_exit_ctrl", 64'(ctrl), 64'b000000);

    // backpressure beats jump and load-use
    ex_ready = 0; ex_jump_signal = 1; ex_jump_pc = 64'h300; #1;
    chk("bp_jump_ctrl", 64'(ctrl), 64'b011000);
    tick();
    chk("bp_jump_noacc", 64'(ctrl), 64'b011000);
    chk("bp_jump_rcnt", 64'(redirect_count), 2);
    ex_jump_signal = 0; ex_is_mem_load = 1; ex_dst_reg = 5; id_src1 = 5; #1;
    chk("bp_lu_ctrl", 64'(ctrl), 64'b011000);
    tick();
    chk("bp_lu_lcnt", 64'(loaduse_count), 2);
    idle_inputs();

    // wrap: 2 cycles per jump with ack held high
    ex_jump_signal = 1; ex_jump_pc = 64'h64; if_redirect_ack = 1;
    for (int i = 0; i < 253; i++) begin
      tick(); tick();
    end
    chk("wrap_pre_rcnt", 64'(redirect_count), 255);
    tick(); tick();
    chk("wrap_rcnt", 64'(redirect_count), 0);
    idle_inputs();

    // asynchronous reset while in REDIRECT
    ex_jump_signal = 1; ex_jump_pc = 64'h64;
    tick(); ex_jump_signal = 0; #1;
    chk("rr_valid", 64'(if_redirect_valid), 1);
    chk("rr_rcnt", 64'(redirect_count), 1);
    reset = 0; #1;
    chk("rr_async_ctrl", 64'(ctrl), 64'b000000);
    chk("rr_async_rcnt", 64'(redirect_count), 0);
    chk("rr_async_lcnt", 64'(loaduse_count), 0);
    #1 reset = 1;
    tick(); tick();
    chk("rr_release_ctrl", 64'(ctrl), 64'b000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
